// File: rtl/mux2_bus_arbiter.sv
// mux2_bus_arbiter: two-requester round-robin arbiter steering a shared mux_2NtoN datapath.
// Optional burst locking is compiled in with `define ARB_LOCK_EN.
module mux_2NtoN #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         s_i,
    input  logic         enable_i,
    output logic [N-1:0] o_o
);
    assign o_o = enable_i ? (s_i ? b_i : a_i) : '0;
endmodule

module mux2_bus_arbiter #(
    parameter int N = 32
`ifdef ARB_LOCK_EN
    , parameter int MAX_LOCK = 4
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] data0,
    input  logic [N-1:0] data1,
`ifdef ARB_LOCK_EN
    input  logic         lock0,
    input  logic         lock1,
`endif
    output logic         gnt0,
    output logic         gnt1,
    output logic         mux_s,
    output logic         mux_enable,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   granted, cur, req_cur, req_oth, xfer;

`ifdef ARB_LOCK_EN
    localparam int LW = $clog2(MAX_LOCK + 1);
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          hold_lock;
`endif

    always_comb begin
        granted = state_q != IDLE;
        cur     = state_q == GNT1;
        req_cur = cur ? req1 : req0;
        req_oth = cur ? req0 : req1;
        xfer    = granted & out_ready;
        state_d = state_q;
        last_d  = last_q;
`ifdef ARB_LOCK_EN
        hold_lock = xfer & (cur ? lock1 : lock0) & (lock_cnt_q < LW'(MAX_LOCK - 1));
`endif
        if (!granted)
            state_d = (req0 & req1) ? (last_q ? GNT0 : GNT1) : req0 ? GNT0 : req1 ? GNT1 : IDLE;
        else if (xfer) begin
            last_d  = cur;
            state_d = req_oth ? (cur ? GNT0 : GNT1) : req_cur ? state_q : IDLE;
`ifdef ARB_LOCK_EN
            if (hold_lock)
                state_d = state_q;
`endif
        end else if (!req_cur)
            state_d = IDLE;
`ifdef ARB_LOCK_EN
        lock_cnt_d = (state_d != state_q) ? '0 : hold_lock ? lock_cnt_q + 1'b1 : lock_cnt_q;
`endif
    end

    // last resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lock_cnt_q <= '0;
        else
            lock_cnt_q <= lock_cnt_d;
    end
`endif

    assign gnt0       = state_q == GNT0;
    assign gnt1       = state_q == GNT1;
    assign mux_s      = gnt1;
    assign mux_enable = granted;
    assign out_valid  = granted;

    mux_2NtoN #(.N(N)) u_mux (
        .a_i      (data0),
        .b_i      (data1),
        .s_i      (mux_s),
        .enable_i (mux_enable),
        .o_o      (out_data)
    );
endmodule
